// File: rtl/wb_pack_store.sv
// wb_pack_store
//   Packs the serial 8-bit feature-map bytes coming out of write-back into
//   FM SRAM words. It also packs the 6-bit guard maps into guard SRAM words.
//   A full word leaves as a one-cycle write strobe on the cycle after the
//   input that filled it. Each write advances that path's address pointer.
//   A flush_i pulse from write-back writes out any partial words. The block
//   then pulses ctrl_finish and returns to idle.
//
// Optional feature macro: WB_PACK_STATS_EN
//   When defined, nz_count_o is a 16-bit saturating count of the FM bytes
//   stored since the last accepted start.
//   When undefined, nz_count_o is tied to 0 and no counter is built.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ctrl_valid / ctrl_ready     layer start handshake (ready = idle)
//   ctrl_finish                 one-cycle pulse, all words written
//   fm_base_i, guard_base_i     start addresses, latched on accept
//   data_i / data_i_valid       FM byte stream (no backpressure)
//   guard_i / guard_i_valid     guard map stream
//   flush_i                     end of layer from write-back
//   fm_wr_*                     FM SRAM write port (byte k at [8k+7:8k])
//   guard_wr_*                  guard SRAM write port (group g at [6g+5:6g])
//   err_o                       sticky: input activity outside RUN
//   nz_count_o                  FM bytes stored this layer (stats build only)
//
// state  | meaning
// IDLE   | waiting for ctrl_valid, ctrl_ready high
// RUN    | packing bytes and guards, full words written as they fill
// FLUSH  | partial words (if any) are on the write ports this cycle
// FINISH | ctrl_finish pulse, back to IDLE next cycle
module wb_pack_store #(
  parameter int FM_WORD_BYTES = 8,
  parameter int GUARD_GROUPS  = 4,
  parameter int FM_ADDR_W     = 12,
  parameter int GUARD_ADDR_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ctrl_valid,
  output logic                      ctrl_ready,
  output logic                      ctrl_finish,
  input  logic [FM_ADDR_W-1:0]      fm_base_i,
  input  logic [GUARD_ADDR_W-1:0]   guard_base_i,
  input  logic [7:0]                data_i,
  input  logic                      data_i_valid,
  input  logic [5:0]                guard_i,
  input  logic                      guard_i_valid,
  input  logic                      flush_i,
  output logic                      fm_wr_en,
  output logic [FM_ADDR_W-1:0]      fm_wr_addr,
  output logic [8*FM_WORD_BYTES-1:0] fm_wr_data,
  output logic                      guard_wr_en,
  output logic [GUARD_ADDR_W-1:0]   guard_wr_addr,
  output logic [6*GUARD_GROUPS-1:0] guard_wr_data,
  output logic                      err_o,
  output logic [15:0]               nz_count_o
);

  localparam int FMW = 8 * FM_WORD_BYTES;
  localparam int GW  = 6 * GUARD_GROUPS;
  localparam int BCW = $clog2(FM_WORD_BYTES + 1);
  localparam int GCW = $clog2(GUARD_GROUPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [FM_ADDR_W-1:0]    fm_ptr;
  logic [GUARD_ADDR_W-1:0] guard_ptr;
  logic [BCW-1:0]          byte_cnt, byte_cnt_nxt;
  logic [GCW-1:0]          grp_cnt, grp_cnt_nxt;
  logic [FMW-1:0]          fm_pack, fm_pack_nxt;
  logic [GW-1:0]           guard_pack, guard_pack_nxt;
  logic                    fm_emit, guard_emit;
  logic                    start, run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ctrl_ready  = 1'b0;
    ctrl_finish = 1'b0;
    case (state)
      S_IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) state_nxt = S_RUN;
      end
      S_RUN:    if (flush_i) state_nxt = S_FLUSH;
      S_FLUSH:  state_nxt = S_FINISH;
      S_FINISH: begin
        ctrl_finish = 1'b1;
        state_nxt   = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign start = (state == S_IDLE) && ctrl_valid;
  assign run   = (state == S_RUN);

  // The packed word, including the byte or guard arriving this cycle, is
  // written out on the next edge. This covers two cases: the new input
  // fills the word, or a flush arrives with the word non-empty. A word that
  // the flush-cycle input fills exactly is therefore written only once.
  always_comb begin
    fm_pack_nxt  = fm_pack;
    byte_cnt_nxt = byte_cnt;
    if (data_i_valid) begin
      for (int k = 0; k < FM_WORD_BYTES; k++)
        if (byte_cnt == BCW'(k)) fm_pack_nxt[8*k +: 8] = data_i;
      byte_cnt_nxt = byte_cnt + BCW'(1);
    end
    fm_emit = (byte_cnt_nxt == BCW'(FM_WORD_BYTES)) ||
              (flush_i && (byte_cnt_nxt != '0));
  end

  always_comb begin
    guard_pack_nxt = guard_pack;
    grp_cnt_nxt    = grp_cnt;
    if (guard_i_valid) begin
      for (int g = 0; g < GUARD_GROUPS; g++)
        if (grp_cnt == GCW'(g)) guard_pack_nxt[6*g +: 6] = guard_i;
      grp_cnt_nxt = grp_cnt + GCW'(1);
    end
    guard_emit = (grp_cnt_nxt == GCW'(GUARD_GROUPS)) ||
                 (flush_i && (grp_cnt_nxt != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_ptr        <= '0;
      guard_ptr     <= '0;
      byte_cnt      <= '0;
      grp_cnt       <= '0;
      fm_pack       <= '0;
      guard_pack    <= '0;
      fm_wr_en      <= 1'b0;
      fm_wr_addr    <= '0;
      fm_wr_data    <= '0;
      guard_wr_en   <= 1'b0;
      guard_wr_addr <= '0;
      guard_wr_data <= '0;
      err_o         <= 1'b0;
    end else begin
      fm_wr_en    <= 1'b0;
      guard_wr_en <= 1'b0;
      if (start) begin
        fm_ptr     <= fm_base_i;
        guard_ptr  <= guard_base_i;
        byte_cnt   <= '0;
        grp_cnt    <= '0;
        fm_pack    <= '0;
        guard_pack <= '0;
        err_o      <= 1'b0;
      end else begin
        if (!run && (data_i_valid || guard_i_valid || flush_i)) err_o <= 1'b1;
        if (run) begin
          if (fm_emit) begin
            fm_wr_en   <= 1'b1;
            fm_wr_addr <= fm_ptr;
            fm_wr_data <= fm_pack_nxt;
            fm_ptr     <= fm_ptr + FM_ADDR_W'(1);
            fm_pack    <= '0;
            byte_cnt   <= '0;
          end else begin
            fm_pack  <= fm_pack_nxt;
            byte_cnt <= byte_cnt_nxt;
          end
          if (guard_emit) begin
            guard_wr_en   <= 1'b1;
            guard_wr_addr <= guard_ptr;
            guard_wr_data <= guard_pack_nxt;
            guard_ptr     <= guard_ptr + GUARD_ADDR_W'(1);
            guard_pack    <= '0;
            grp_cnt       <= '0;
          end else begin
            guard_pack <= guard_pack_nxt;
            grp_cnt    <= grp_cnt_nxt;
          end
        end
      end
    end
  end

`ifdef WB_PACK_STATS_EN
  logic [15:0] nz_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       nz_cnt <= '0;
    else if (start)                                   nz_cnt <= '0;
    else if (run && data_i_valid && nz_cnt != 16'hFFFF) nz_cnt <= nz_cnt + 16'd1;
  end

  assign nz_count_o = nz_cnt;
`else
  assign nz_count_o = '0;
`endif

endmodule

// File: tb/tb_wb_pack_store.sv
module tb_wb_pack_store;
  localparam int FMB = 8;
  localparam int GG  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready, ctrl_finish;
  logic [11:0] fm_base_i = '0;
  logic [9:0]  guard_base_i = '0;
  logic [7:0]  data_i = '0;
  logic        data_i_valid = 1'b0;
  logic [5:0]  guard_i = '0;
  logic        guard_i_valid = 1'b0;
  logic        flush_i = 1'b0;
  logic        fm_wr_en, guard_wr_en, err_o;
  logic [11:0] fm_wr_addr;
  logic [63:0] fm_wr_data;
  logic [9:0]  guard_wr_addr;
  logic [23:0] guard_wr_data;
  logic [15:0] nz_count_o;

  wb_pack_store dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_finish(ctrl_finish), .fm_base_i(fm_base_i), .guard_base_i(guard_base_i),
    .data_i(data_i), .data_i_valid(data_i_valid), .guard_i(guard_i),
    .guard_i_valid(guard_i_valid), .flush_i(flush_i), .fm_wr_en(fm_wr_en),
    .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data), .guard_wr_en(guard_wr_en),
    .guard_wr_addr(guard_wr_addr), .guard_wr_data(guard_wr_data), .err_o(err_o),
    .nz_count_o(nz_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // observed writes, stamped with the cycle in which the strobe was high
  logic [11:0] obs_fm_addr[$];
  logic [63:0] obs_fm_data[$];
  int          obs_fm_cyc[$];
  logic [9:0]  obs_g_addr[$];
  logic [23:0] obs_g_data[$];
  int          obs_g_cyc[$];
  int          fin_cyc[$];

  always @(negedge clk) begin
    if (fm_wr_en) begin
      obs_fm_addr.push_back(fm_wr_addr);
      obs_fm_data.push_back(fm_wr_data);
      obs_fm_cyc.push_back(cyc);
    end
    if (guard_wr_en) begin
      obs_g_addr.push_back(guard_wr_addr);
      obs_g_data.push_back(guard_wr_data);
      obs_g_cyc.push_back(cyc);
    end
    if (ctrl_finish) fin_cyc.push_back(cyc);
  end

  // per-cycle stimulus for one layer; the last cycle carries flush_i
  bit          sdv[0:255];
  logic [7:0]  sd[0:255];
  bit          sgv[0:255];
  logic [5:0]  sg[0:255];
  int          st[0:255];
  int          fl_cyc;
  bit          rand_ctrl = 1'b0;
  logic        rdy_run, err_run, fin2, rdy2, fin3, rdy3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_fm_addr.delete(); obs_fm_data.delete(); obs_fm_cyc.delete();
    obs_g_addr.delete();  obs_g_data.delete();  obs_g_cyc.delete();
    fin_cyc.delete();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 256; i++) begin
      sdv[i] = 1'b0; sd[i] = 8'($urandom);
      sgv[i] = 1'b0; sg[i] = 6'($urandom);
    end
  endtask

  task automatic run_layer(input logic [11:0] fb, input logic [9:0] gb, input int n);
    clear_obs();
    ctrl_valid = 1'b1; fm_base_i = fb; guard_base_i = gb;
    tick();
    ctrl_valid = 1'b0;
    fm_base_i = 12'($urandom); guard_base_i = 10'($urandom);
    rdy_run = ctrl_ready;
    err_run = err_o;
    for (int i = 0; i < n; i++) begin
      data_i_valid = sdv[i]; data_i = sd[i];
      guard_i_valid = sgv[i]; guard_i = sg[i];
      flush_i = (i == n - 1);
      if (rand_ctrl) ctrl_valid = 1'($urandom_range(0, 1));
      st[i] = cyc;
      tick();
    end
    data_i_valid = 1'b0; guard_i_valid = 1'b0; flush_i = 1'b0; ctrl_valid = 1'b0;
    fl_cyc = st[n-1];
    tick();
    fin2 = ctrl_finish; rdy2 = ctrl_ready;
    tick();
    fin3 = ctrl_finish; rdy3 = ctrl_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (ctrl_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ctrl_ready); end
    checks++; if ({fm_wr_en, guard_wr_en, ctrl_finish, err_o} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {fm_wr_en, guard_wr_en, ctrl_finish, err_o}); end
    checks++; if ({fm_wr_addr, fm_wr_data, guard_wr_addr, guard_wr_data, nz_count_o} !== '0) begin failures++; $display("FAIL reset_data got nonzero data/addr/count exp=0"); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fm_pack();
    clear_stim();
    for (int i = 0; i < 8; i++) begin sdv[i] = 1'b1; sd[i] = 8'(i + 1); end
    sgv[0] = 1; sg[0] = 6'h3F; sgv[1] = 1; sg[1] = 6'h01;
    sgv[2] = 1; sg[2] = 6'h20; sgv[3] = 1; sg[3] = 6'h15;
    run_layer(12'h010, 10'h020, 9);
    checks++; if (rdy_run !== 1'b0) begin failures++; $display("FAIL pack_ready_in_run got=%b exp=0", rdy_run); end
    checks++; if (obs_fm_data.size() != 1) begin failures++; $display("FAIL pack_fm_count got=%0d exp=1", obs_fm_data.size()); end
    else begin
      checks++; if (obs_fm_addr[0] !== 12'h010) begin failures++; $display("FAIL pack_fm_addr got=%h exp=010", obs_fm_addr[0]); end
      checks++; if (obs_fm_data[0] !== 64'h0807060504030201) begin failures++; $display("FAIL pack_fm_data got=%h exp=0807060504030201", obs_fm_data[0]); end
      checks++; if (obs_fm_cyc[0] != st[7] + 1) begin failures++; $display("FAIL pack_fm_latency got=%0d exp=%0d", obs_fm_cyc[0], st[7] + 1); end
    end
    checks++; if (obs_g_data.size() != 1) begin failures++; $display("FAIL pack_g_count got=%0d exp=1", obs_g_data.size()); end
    else begin
      checks++; if (obs_g_addr[0] !== 10'h020) begin failures++; $display("FAIL pack_g_addr got=%h exp=020", obs_g_addr[0]); end
      checks++; if (obs_g_data[0] !== 24'h56007F) begin failures++; $display("FAIL pack_g_data got=%h exp=56007f", obs_g_data[0]); end
      checks++; if (obs_g_cyc[0] != st[3] + 1) begin failures++; $display("FAIL pack_g_latency got=%0d exp=%0d", obs_g_cyc[0], st[3] + 1); end
    end
  endtask

  task automatic test_flush();
    clear_stim();
    sdv[0] = 1; sd[0] = 8'hAA; sdv[1] = 1; sd[1] = 8'hBB; sdv[2] = 1; sd[2] = 8'hCC;
    sgv[0] = 1; sg[0] = 6'h2A;
    run_layer(12'h100, 10'h200, 4);
    checks++; if (obs_fm_data.size() != 1 || obs_g_data.size() != 1) begin failures++; $display("FAIL flush_counts got fm=%0d g=%0d exp=1/1", obs_fm_data.size(), obs_g_data.size()); end
    else begin
      checks++; if (obs_fm_data[0] !== 64'h0000000000CCBBAA || obs_fm_addr[0] !== 12'h100) begin failures++; $display("FAIL flush_fm got=%h@%h exp=0000000000ccbbaa@100", obs_fm_data[0], obs_fm_addr[0]); end
      checks++; if (obs_g_data[0] !== 24'h00002A || obs_g_addr[0] !== 10'h200) begin failures++; $display("FAIL flush_g got=%h@%h exp=00002a@200", obs_g_data[0], obs_g_addr[0]); end
      checks++; if (obs_fm_cyc[0] != fl_cyc + 1 || obs_g_cyc[0] != fl_cyc + 1) begin failures++; $display("FAIL flush_time got=%0d/%0d exp=%0d", obs_fm_cyc[0], obs_g_cyc[0], fl_cyc + 1); end
    end
    checks++; if (fin_cyc.size() != 1 || fin2 !== 1'b1) begin failures++; $display("FAIL flush_finish got pulses=%0d at_t2=%b exp=1/1", fin_cyc.size(), fin2); end
    else begin
      checks++; if (fin_cyc[0] != fl_cyc + 2) begin failures++; $display("FAIL flush_finish_time got=%0d exp=%0d", fin_cyc[0], fl_cyc + 2); end
    end
    checks++; if (rdy2 !== 1'b0 || rdy3 !== 1'b1 || fin3 !== 1'b0) begin failures++; $display("FAIL flush_ready got t2=%b t3=%b fin3=%b exp=0/1/0", rdy2, rdy3, fin3); end
  endtask

  task automatic test_wrap();
    clear_stim();
    for (int i = 0; i < 16; i++) begin sdv[i] = 1'b1; sd[i] = 8'(8'h40 + i); end
    run_layer(12'hFFF, 10'h3FF, 17);
    checks++; if (obs_fm_addr.size() != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", obs_fm_addr.size()); end
    else begin
      checks++; if (obs_fm_addr[0] !== 12'hFFF || obs_fm_addr[1] !== 12'h000) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=fff,000", obs_fm_addr[0], obs_fm_addr[1]); end
      checks++; if (obs_fm_data[1] !== 64'h4F4E4D4C4B4A4948) begin failures++; $display("FAIL wrap_data got=%h exp=4f4e4d4c4b4a4948", obs_fm_data[1]); end
    end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err_o); end
  endtask

  task automatic test_flush_full();
    logic [15:0] exp_nz;
    clear_stim();
    for (int i = 0; i < 8; i++) begin sdv[i] = 1'b1; sd[i] = 8'(8'hF0 + i); end
    run_layer(12'h300, 10'h000, 8);
    checks++; if (obs_fm_data.size() != 1) begin failures++; $display("FAIL flushfull_count got=%0d exp=1", obs_fm_data.size()); end
    else begin
      checks++; if (obs_fm_data[0] !== 64'hF7F6F5F4F3F2F1F0 || obs_fm_cyc[0] != fl_cyc + 1) begin failures++; $display("FAIL flushfull_word got=%h@c%0d exp=f7f6f5f4f3f2f1f0@c%0d", obs_fm_data[0], obs_fm_cyc[0], fl_cyc + 1); end
    end
    checks++; if (obs_g_data.size() != 0) begin failures++; $display("FAIL flushfull_guard got=%0d exp=0", obs_g_data.size()); end
`ifdef WB_PACK_STATS_EN
    exp_nz = 16'd8;
`else
    exp_nz = 16'd0;
`endif
    checks++; if (nz_count_o !== exp_nz) begin failures++; $display("FAIL flushfull_nz got=%0d exp=%0d", nz_count_o, exp_nz); end
  endtask

  task automatic test_reset_abort();
    clear_obs();
    ctrl_valid = 1'b1; fm_base_i = 12'h500; tick(); ctrl_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin data_i_valid = 1'b1; data_i = 8'(8'h11 * (i + 1)); tick(); end
    data_i_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (ctrl_ready !== 1'b1 || nz_count_o !== 16'd0) begin failures++; $display("FAIL abort_state got ready=%b nz=%0d exp=1/0", ctrl_ready, nz_count_o); end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (obs_fm_data.size() != 0 || fin_cyc.size() != 0) begin failures++; $display("FAIL abort_nowrite got writes=%0d finish=%0d exp=0/0", obs_fm_data.size(), fin_cyc.size()); end
    clear_stim();
    sdv[0] = 1; sd[0] = 8'h5A; sdv[1] = 1; sd[1] = 8'hA5;
    run_layer(12'h600, 10'h010, 3);
    checks++; if (obs_fm_data.size() != 1 || obs_fm_data[0] !== 64'h000000000000A55A) begin failures++; $display("FAIL abort_next_layer got n=%0d data=%h exp=1 000000000000a55a", obs_fm_data.size(), obs_fm_data.size() ? obs_fm_data[0] : 64'h0); end
  endtask

  task automatic test_err_idle();
    clear_obs();
    data_i_valid = 1'b1; data_i = 8'h77;
    tick();
    data_i_valid = 1'b0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_o); end
    tick(); tick();
    checks++; if (err_o !== 1'b1 || obs_fm_data.size() != 0 || ctrl_ready !== 1'b1) begin failures++; $display("FAIL err_sticky got err=%b writes=%0d ready=%b exp=1/0/1", err_o, obs_fm_data.size(), ctrl_ready); end
    clear_stim();
    sdv[0] = 1; sd[0] = 8'h01;
    run_layer(12'h020, 10'h020, 2);
    checks++; if (err_run !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL err_clear got run=%b end=%b exp=0/0", err_run, err_o); end
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_flush_idle got=%b exp=1", err_o); end
  endtask

  task automatic test_random();
    logic [7:0]  bl[$];
    int          bc[$];
    logic [5:0]  gl[$];
    int          gc[$];
    logic [63:0] ed;
    logic [23:0] eg;
    logic [11:0] fb;
    logic [9:0]  gb;
    int n, nw, ng, last, ecyc;
    logic [15:0] exp_nz;
    rand_ctrl = 1'b1;
    for (int layer = 0; layer < 8; layer++) begin
      clear_stim();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        sdv[i] = ($urandom_range(0, 9) < 7);
        sgv[i] = ($urandom_range(0, 9) < 4);
      end
      fb = 12'($urandom); gb = 10'($urandom);
      run_layer(fb, gb, n);
      bl.delete(); bc.delete(); gl.delete(); gc.delete();
      for (int i = 0; i < n; i++) begin
        if (sdv[i]) begin bl.push_back(sd[i]); bc.push_back(st[i]); end
        if (sgv[i]) begin gl.push_back(sg[i]); gc.push_back(st[i]); end
      end
      nw = (bl.size() + FMB - 1) / FMB;
      ng = (gl.size() + GG - 1) / GG;
      checks++; if (obs_fm_data.size() != nw) begin failures++; $display("FAIL rand%0d_fm_count got=%0d exp=%0d", layer, obs_fm_data.size(), nw); end
      for (int w = 0; w < nw && w < obs_fm_data.size(); w++) begin
        ed = '0;
        for (int k = 0; k < FMB; k++) if (w * FMB + k < bl.size()) ed[8*k +: 8] = bl[w * FMB + k];
        last = w * FMB + FMB - 1;
        ecyc = (last < bl.size()) ? bc[last] + 1 : fl_cyc + 1;
        checks++; if (obs_fm_data[w] !== ed || obs_fm_addr[w] !== fb + 12'(w) || obs_fm_cyc[w] != ecyc) begin
          failures++; $display("FAIL rand%0d_fm_word%0d got=%h@%h c%0d exp=%h@%h c%0d", layer, w, obs_fm_data[w], obs_fm_addr[w], obs_fm_cyc[w], ed, fb + 12'(w), ecyc);
        end
      end
      checks++; if (obs_g_data.size() != ng) begin failures++; $display("FAIL rand%0d_g_count got=%0d exp=%0d", layer, obs_g_data.size(), ng); end
      for (int w = 0; w < ng && w < obs_g_data.size(); w++) begin
        eg = '0;
        for (int k = 0; k < GG; k++) if (w * GG + k < gl.size()) eg[6*k +: 6] = gl[w * GG + k];
        last = w * GG + GG - 1;
        ecyc = (last < gl.size()) ? gc[last] + 1 : fl_cyc + 1;
        checks++; if (obs_g_data[w] !== eg || obs_g_addr[w] !== gb + 10'(w) || obs_g_cyc[w] != ecyc) begin
          failures++; $display("FAIL rand%0d_g_word%0d got=%h@%h c%0d exp=%h@%h c%0d", layer, w, obs_g_data[w], obs_g_addr[w], obs_g_cyc[w], eg, gb + 10'(w), ecyc);
        end
      end
`ifdef WB_PACK_STATS_EN
      exp_nz = 16'(bl.size());
`else
      exp_nz = 16'd0;
`endif
      checks++; if (nz_count_o !== exp_nz || err_o !== 1'b0) begin failures++; $display("FAIL rand%0d_status got nz=%0d err=%b exp=%0d/0", layer, nz_count_o, err_o, exp_nz); end
      checks++; if (fin_cyc.size() != 1 || rdy3 !== 1'b1) begin failures++; $display("FAIL rand%0d_finish got pulses=%0d ready=%b exp=1/1", layer, fin_cyc.size(), rdy3); end
    end
    rand_ctrl = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fm_pack();
    test_flush();
    test_wrap();
    test_flush_full();
    test_reset_abort();
    test_err_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
